ysyx_lsu_axi_bridge: RTL and testbench
======================================

# ysyx_lsu_axi_bridge

Converts the LSU's level-style load/store request interface into an AXI4-Lite master with one outstanding transaction. Sits directly downstream of the LSU and upstream of the memory-side crossbar. It handles the handshake sequencing, byte-lane alignment of stores and the response pulses back to the LSU. Read data is returned as a raw word; the LSU performs load alignment and sign extension.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (bus is 32-bit; only 32 supported)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu_araddr  in  ADDR_W  load address
- lsu_arvalid  in  1  load request, level
- lsu_rstrb  in  8  load byte mask (1/3/f); informational only, unused on AXI-Lite
- lsu_rdata  out  DATA_W  raw read word
- lsu_rvalid  out  1  one-cycle load-done pulse
- lsu_awaddr  in  ADDR_W  store address
- lsu_awvalid, lsu_wvalid  in  1 each  store request, level; store starts when both high
- lsu_wdata  in  DATA_W  store data, LSB-justified
- lsu_wstrb  in  8  store mask, LSB-justified (1/3/f)
- lsu_wready  out  1  one-cycle store-done pulse
- lsu_bus_err  out  1  sticky bus-error flag (see Configuration)
- AXI4-Lite master: m_araddr[ADDR_W] out, m_arvalid out, m_arready in, m_rdata[DATA_W] in, m_rresp[2] in, m_rvalid in, m_rready out, m_awaddr[ADDR_W] out, m_awvalid out, m_awready in, m_wdata[DATA_W] out, m_wstrb[4] out, m_wvalid out, m_wready in, m_bresp[2] in, m_bvalid in, m_bready out

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B, DONE.
- IDLE: load request takes priority over a simultaneous store. On load: capture address, go to RD_AR. On store (lsu_awvalid & lsu_wvalid): capture the aligned address, data and strobe, clear the aw_done/w_done flags, go to WR_REQ.
- RD_AR: m_arvalid=1 and m_araddr is held. On m_arready, go to RD_R.
- RD_R: m_rready=1. On m_rvalid, register m_rdata into lsu_rdata and go to DONE with the read flag set.
- WR_REQ: m_awvalid=!aw_done and m_wvalid=!w_done; AW and W complete independently, in either order or together. Set aw_done on the m_awready handshake and w_done on the m_wready handshake. When both are done, go to WR_B.
- WR_B: m_bready=1. On m_bvalid, go to DONE with the write flag set.
- DONE: lsu_rvalid or lsu_wready is high for exactly this one cycle. The LSU request inputs are ignored here. Next state is IDLE.
- Store alignment (lo = lsu_awaddr[1:0]):
  - m_wdata = lsu_wdata << (8*lo), truncated to 32 bits.
  - m_wstrb = (lsu_wstrb[3:0] << lo), truncated to 4 bits.
  - m_awaddr = lsu_awaddr unchanged.
- m_araddr = lsu_araddr unchanged; no read alignment.
- All AXI outputs and all LSU-side outputs are driven from registers or state decode; there is no combinational path from an input to an output.

## Timing
- Reset values: state=IDLE; all valid/ready outputs 0; lsu_rdata=0; m_araddr, m_awaddr, m_wdata = 0; m_wstrb=0; lsu_bus_err=0.
- Load, best case: request seen at edge 0 → m_arvalid high in cycle 1 → arready in cycle 1 → rvalid in cycle 2 → lsu_rvalid in cycle 3. Latency is 3 cycles plus slave wait states.
- Store, best case: m_awvalid and m_wvalid high in cycle 1, both accepted → bvalid in cycle 2 → lsu_wready in cycle 3.
- Handshake contract: the LSU drops its request in the DONE cycle. A back-to-back request is sampled the cycle after DONE, so the minimum issue interval is 4 cycles.
- Once a valid is raised it stays high, with address, data and strobe stable, until its handshake completes (AXI rule).
- If reset is asserted mid-transaction, the FSM returns to IDLE immediately, no response pulse is generated, and the in-flight AXI transaction is abandoned.

## Configuration
- YSYX_LSU_BUS_ERR_EN defined:
  - A nonzero m_rresp or m_bresp at its handshake sets lsu_bus_err. It stays set until reset.
  - In simulation, $display prints the address and resp code.
  - The transaction still completes normally and the response pulse is still generated.
- Undefined: resp is ignored and lsu_bus_err is tied to 0.

## Test plan
- Load, zero-wait slave. lsu_araddr=0x8000_0004, m_rdata=0xDEADBEEF. Required: m_araddr=0x8000_0004, lsu_rdata=0xDEADBEEF, lsu_rvalid is a single pulse at cycle 3.
- SB to 0x8000_0003 with wdata=0x000000A5 and wstrb=1. Required: m_wstrb=4'b1000, m_wdata=0xA5000000. SH to ...02 with 0x1234 and wstrb=3. Required: m_wstrb=4'b1100, m_wdata=0x12340000.
- Store with a slave asserting m_wready 3 cycles before m_awready. Required: m_wvalid drops after its handshake, m_awvalid stays high until awready, and there is exactly one lsu_wready pulse after bvalid.
- Simultaneous load and store in IDLE. Required: the load is served first. The store is accepted in the IDLE cycle after the load's DONE, provided the store request is still held.
- Reset asserted during RD_R with slave rvalid pending. Required: all outputs return to their reset values asynchronously, and there is no lsu_rvalid pulse after release.
- With YSYX_LSU_BUS_ERR_EN defined, m_bresp=2'b10. Required: lsu_wready pulses and lsu_bus_err=1 stays set until reset. With the macro undefined: lsu_bus_err=0.

Source files
------------

// File: rtl/ysyx_lsu_axi_bridge.sv
// ----------------------------------------------------------------------------
// ysyx_lsu_axi_bridge
//
// Turns the LSU's level-style load/store requests into AXI4-Lite master
// transactions, one outstanding at a time. Loads take priority over a
// simultaneous store. Stores are byte-lane aligned here: data and strobe are
// shifted by the low address bits. Loads return the raw bus word, and the LSU
// does its own alignment and sign extension.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   lsu_araddr/arvalid/rstrb      load request (rstrb unused on AXI-Lite)
//   lsu_rdata/rvalid              raw read word, one-cycle load-done pulse
//   lsu_awaddr/awvalid/wvalid     store request; starts when both valids high
//   lsu_wdata/wstrb               LSB-justified store data and mask
//   lsu_wready                    one-cycle store-done pulse
//   lsu_bus_err                   sticky bus-error flag
//   m_*                           AXI4-Lite master channels AR/R/AW/W/B
//
// Configuration
//   YSYX_LSU_BUS_ERR_EN  when defined, a nonzero RRESP/BRESP at its handshake
//                        sets lsu_bus_err until reset. The transaction still
//                        completes normally. When undefined, lsu_bus_err is 0.
// ----------------------------------------------------------------------------
module ysyx_lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // bus is 32-bit; only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  // LSU load side
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  // LSU store side
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic              lsu_wvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  output logic              lsu_wready,
  output logic              lsu_bus_err,
  // AXI4-Lite master
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_done_q, w_done_q;
  logic              is_wr_q;   // DONE pulses lsu_wready if set, else lsu_rvalid

  logic [1:0] lo;
  logic       start_load, start_store;
  logic       aw_hs, w_hs, r_hs, b_hs;

  assign lo          = lsu_awaddr[1:0];
  assign start_load  = (state_q == IDLE) && lsu_arvalid;
  assign start_store = (state_q == IDLE) && !lsu_arvalid && lsu_awvalid && lsu_wvalid;
  assign aw_hs       = m_awvalid && m_awready;
  assign w_hs        = m_wvalid  && m_wready;
  assign r_hs        = m_rready  && m_rvalid;
  assign b_hs        = m_bready  && m_bvalid;

  // Read strobe, the upper store-mask bits and (in the default build) the
  // response codes have no use on a 32-bit AXI-Lite bus.
  logic unused_inputs;
  assign unused_inputs = ^{lsu_rstrb, lsu_wstrb[7:4], m_rresp, m_bresp};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_load)       state_d = RD_AR;
               else if (start_store) state_d = WR_REQ;
      RD_AR:   if (m_arready)        state_d = RD_R;
      RD_R:    if (m_rvalid)         state_d = DONE;
      // AW and W complete independently; leave once both have been accepted.
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
      WR_B:    if (m_bvalid)         state_d = DONE;
      DONE:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode: valid/ready are pure state decode, never input-driven.
  // -------------------------------------------------------------------------
  always_comb begin
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_wready = 1'b0;
    case (state_q)
      RD_AR:  m_arvalid = 1'b1;
      RD_R:   m_rready  = 1'b1;
      WR_REQ: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
      end
      WR_B:   m_bready  = 1'b1;
      DONE: begin
        lsu_rvalid = !is_wr_q;
        lsu_wready = is_wr_q;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture and read data. Everything is captured once in IDLE, which
  // keeps address/data/strobe stable while the valids are up.
  // -------------------------------------------------------------------------
  // NOTE: the datapath registers are reset too, because their reset value of
  // zero is visible on the AXI and LSU outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      is_wr_q   <= 1'b0;
    end else begin
      if (start_load) begin
        araddr_q <= lsu_araddr;
        is_wr_q  <= 1'b0;
      end
      if (start_store) begin
        awaddr_q  <= lsu_awaddr;
        wdata_q   <= lsu_wdata << {lo, 3'b000};
        wstrb_q   <= lsu_wstrb[3:0] << lo;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        is_wr_q   <= 1'b1;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs)  rdata_q   <= m_rdata;
    end
  end

  assign m_araddr  = araddr_q;
  assign m_awaddr  = awaddr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign lsu_rdata = rdata_q;

  // -------------------------------------------------------------------------
  // Sticky bus error
  // -------------------------------------------------------------------------
`ifdef YSYX_LSU_BUS_ERR_EN
  logic bus_err_q;
  logic rd_err, wr_err;

  assign rd_err = r_hs && (m_rresp != 2'b00);
  assign wr_err = b_hs && (m_bresp != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bus_err_q <= 1'b0;
    else if (rd_err || wr_err) bus_err_q <= 1'b1;
  end

  assign lsu_bus_err = bus_err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && rd_err) $display("ysyx_lsu_axi_bridge: read error addr=%h rresp=%b", araddr_q, m_rresp);
    if (rst_n && wr_err) $display("ysyx_lsu_axi_bridge: write error addr=%h bresp=%b", awaddr_q, m_bresp);
  end
`endif
`else
  assign lsu_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// ----------------------------------------------------------------------------
// tb_ysyx_lsu_axi_bridge
//
// Directed bench for ysyx_lsu_axi_bridge. The bench plays both the LSU and
// the AXI-Lite slave. Inputs change 1 time unit after each rising edge, and
// outputs are compared at that same point, well away from the next edge.
// Expected bus-error behaviour follows YSYX_LSU_BUS_ERR_EN.
// ----------------------------------------------------------------------------
module tb_ysyx_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata, lsu_rdata;
  logic        lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready, lsu_bus_err;
  logic [7:0]  lsu_rstrb, lsu_wstrb;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef YSYX_LSU_BUS_ERR_EN
  localparam logic BERR_EXP = 1'b1;
`else
  localparam logic BERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_rstrb   (lsu_rstrb),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_awaddr  (lsu_awaddr),
    .lsu_awvalid (lsu_awvalid),
    .lsu_wvalid  (lsu_wvalid),
    .lsu_wdata   (lsu_wdata),
    .lsu_wstrb   (lsu_wstrb),
    .lsu_wready  (lsu_wready),
    .lsu_bus_err (lsu_bus_err),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .m_awaddr    (m_awaddr),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " m_arvalid"},   m_arvalid,   32'h0);
    check({tag, " m_rready"},    m_rready,    32'h0);
    check({tag, " m_awvalid"},   m_awvalid,   32'h0);
    check({tag, " m_wvalid"},    m_wvalid,    32'h0);
    check({tag, " m_bready"},    m_bready,    32'h0);
    check({tag, " lsu_rvalid"},  lsu_rvalid,  32'h0);
    check({tag, " lsu_wready"},  lsu_wready,  32'h0);
    check({tag, " lsu_rdata"},   lsu_rdata,   32'h0);
    check({tag, " m_araddr"},    m_araddr,    32'h0);
    check({tag, " m_awaddr"},    m_awaddr,    32'h0);
    check({tag, " m_wdata"},     m_wdata,     32'h0);
    check({tag, " m_wstrb"},     {28'h0, m_wstrb}, 32'h0);
    check({tag, " lsu_bus_err"}, lsu_bus_err, 32'h0);
  endtask

  // Zero-wait store: AW and W are both accepted in the first cycle and B
  // follows one cycle later. The request is dropped in the DONE cycle.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [7:0] strb, input logic [1:0] bresp,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    lsu_awaddr  = addr;
    lsu_wdata   = data;
    lsu_wstrb   = strb;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    step();                                   // cycle 1: WR_REQ
    check({tag, " awvalid"}, m_awvalid, 32'h1);
    check({tag, " wvalid"},  m_wvalid,  32'h1);
    check({tag, " awaddr"},  m_awaddr,  addr);
    check({tag, " wdata"},   m_wdata,   exp_wdata);
    check({tag, " wstrb"},   {28'h0, m_wstrb}, {28'h0, exp_wstrb});
    step();                                   // cycle 2: WR_B
    check({tag, " awvalid low"}, m_awvalid, 32'h0);
    check({tag, " bready"},      m_bready,  32'h1);
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    m_bresp   = bresp;
    step();                                   // cycle 3: DONE
    check({tag, " wready pulse"}, lsu_wready, 32'h1);
    check({tag, " no rvalid"},    lsu_rvalid, 32'h0);
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    m_bvalid    = 1'b0;
    m_bresp     = 2'b00;
    step();                                   // back in IDLE
    check({tag, " wready drop"}, lsu_wready, 32'h0);
  endtask

  initial begin
    rst_n       = 1'b1;
    lsu_araddr  = '0;
    lsu_arvalid = 1'b0;
    lsu_rstrb   = 8'h0f;
    lsu_awaddr  = '0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    lsu_wdata   = '0;
    lsu_wstrb   = '0;
    m_arready   = 1'b0;
    m_rdata     = '0;
    m_rresp     = 2'b00;
    m_rvalid    = 1'b0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
    m_bresp     = 2'b00;
    m_bvalid    = 1'b0;

    // ---- Reset state -------------------------------------------------------
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---- Load, zero-wait slave --------------------------------------------
    lsu_araddr  = 32'h8000_0004;
    lsu_arvalid = 1'b1;
    m_arready   = 1'b1;
    step();                                   // cycle 1: RD_AR
    check("ld arvalid", m_arvalid, 32'h1);
    check("ld araddr",  m_araddr,  32'h8000_0004);
    check("ld rvalid c1", lsu_rvalid, 32'h0);
    step();                                   // cycle 2: RD_R
    check("ld arvalid low", m_arvalid, 32'h0);
    check("ld rready",      m_rready,  32'h1);
    check("ld rvalid c2",   lsu_rvalid, 32'h0);
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hDEAD_BEEF;
    step();                                   // cycle 3: DONE
    check("ld rvalid c3", lsu_rvalid, 32'h1);
    check("ld rdata",     lsu_rdata,  32'hDEAD_BEEF);
    check("ld no wready", lsu_wready, 32'h0);
    lsu_arvalid = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = 32'h0;
    step();
    check("ld rvalid c4", lsu_rvalid, 32'h0);
    check("ld rdata hold", lsu_rdata, 32'hDEAD_BEEF);

    // ---- Store alignment: SB and SH ---------------------------------------
    run_store("sb", 32'h8000_0003, 32'h0000_00A5, 8'h01, 2'b00, 32'hA500_0000, 4'b1000);
    run_store("sh", 32'h8000_0002, 32'h0000_1234, 8'h03, 2'b00, 32'h1234_0000, 4'b1100);

    // ---- Store, W accepted 3 cycles before AW -----------------------------
    lsu_awaddr  = 32'h8000_0010;
    lsu_wdata   = 32'h1122_3344;
    lsu_wstrb   = 8'h0f;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    m_awready   = 1'b0;
    m_wready    = 1'b1;
    step();                                   // cycle 1: both valids up, W accepted
    check("split awvalid c1", m_awvalid, 32'h1);
    check("split wvalid c1",  m_wvalid,  32'h1);
    step();
    m_wready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("split awvalid c%0d", i), m_awvalid, 32'h1);
      check($sformatf("split wvalid c%0d", i),  m_wvalid,  32'h0);
      check($sformatf("split awaddr c%0d", i),  m_awaddr,  32'h8000_0010);
      check($sformatf("split bready c%0d", i),  m_bready,  32'h0);
      if (i == 4) m_awready = 1'b1;
      step();
    end
    check("split awvalid low", m_awvalid, 32'h0);
    check("split bready",      m_bready,  32'h1);
    check("split no early wready", lsu_wready, 32'h0);
    m_awready = 1'b0;
    m_bvalid  = 1'b1;
    step();                                   // DONE
    check("split wready pulse", lsu_wready, 32'h1);
    check("split wdata",        m_wdata,    32'h1122_3344);
    check("split wstrb",        {28'h0, m_wstrb}, 32'hf);
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    m_bvalid    = 1'b0;
    step();
    check("split wready drop", lsu_wready, 32'h0);
    step();
    check("split single pulse", lsu_wready, 32'h0);

    // ---- Simultaneous load and store: load first --------------------------
    lsu_araddr  = 32'h8000_0008;
    lsu_arvalid = 1'b1;
    lsu_awaddr  = 32'h8000_0020;
    lsu_wdata   = 32'h0000_0055;
    lsu_wstrb   = 8'h01;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    m_arready   = 1'b1;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    step();                                   // RD_AR
    check("prio arvalid", m_arvalid, 32'h1);
    check("prio awvalid", m_awvalid, 32'h0);
    check("prio wvalid",  m_wvalid,  32'h0);
    step();                                   // RD_R
    m_rvalid = 1'b1;
    m_rdata  = 32'hCAFE_F00D;
    step();                                   // DONE (load)
    check("prio rvalid",    lsu_rvalid, 32'h1);
    check("prio rdata",     lsu_rdata,  32'hCAFE_F00D);
    check("prio no wready", lsu_wready, 32'h0);
    lsu_arvalid = 1'b0;
    m_rvalid    = 1'b0;
    step();                                   // IDLE, store still held
    check("prio idle awvalid", m_awvalid, 32'h0);
    check("prio idle rvalid",  lsu_rvalid, 32'h0);
    step();                                   // WR_REQ
    check("prio st awvalid", m_awvalid, 32'h1);
    check("prio st awaddr",  m_awaddr,  32'h8000_0020);
    check("prio st wdata",   m_wdata,   32'h0000_0055);
    check("prio st wstrb",   {28'h0, m_wstrb}, 32'h1);
    step();                                   // WR_B
    m_bvalid = 1'b1;
    step();                                   // DONE (store)
    check("prio st wready", lsu_wready, 32'h1);
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    m_bvalid    = 1'b0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
    step();

    // ---- Reset during RD_R with rvalid pending ----------------------------
    lsu_araddr  = 32'h8000_0040;
    lsu_arvalid = 1'b1;
    m_arready   = 1'b1;
    step();                                   // RD_AR
    step();                                   // RD_R
    check("rst rready", m_rready, 32'h1);
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h1234_5678;
    #2 rst_n = 1'b0;                          // mid-cycle, before the R handshake edge
    #1 check_reset_outputs("async rst");
    lsu_arvalid = 1'b0;
    step();
    m_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst no rvalid %0d", i), lsu_rvalid, 32'h0);
      check($sformatf("rst idle rready %0d", i), m_rready, 32'h0);
      step();
    end

    // ---- Bus error on BRESP=SLVERR ----------------------------------------
    run_store("berr", 32'h8000_0030, 32'h0000_BEEF, 8'h03, 2'b10, 32'h0000_BEEF, 4'b0011);
    check("berr flag", lsu_bus_err, {31'h0, BERR_EXP});
    step();
    step();
    check("berr sticky", lsu_bus_err, {31'h0, BERR_EXP});
    run_store("berr ok", 32'h8000_0031, 32'h0000_0077, 8'h01, 2'b00, 32'h0000_7700, 4'b0010);
    check("berr still sticky", lsu_bus_err, {31'h0, BERR_EXP});
    #2 rst_n = 1'b0;
    #1 check("berr cleared by reset", lsu_bus_err, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
